// File: rtl/hex_display_pager_if.sv
// Bus between the processor debug outputs and the pager. The master drives
// the source words and operator controls; the slave (the pager) returns the
// digit-driver signals.
interface hex_display_pager_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_SOURCES = 2,
  parameter int SEL_W       = 1,
  parameter int WORD_W      = 32,
  parameter int PAGE_W      = 1
);
  logic [NUM_SOURCES*WORD_W-1:0] src_words;
  logic [SEL_W-1:0]              src_sel;
  logic                          page_step;
  logic                          auto_scroll;
  logic                          blank_lz;
  logic [NUM_DIGITS-1:0]         anode;
  logic [3:0]                    hex_digit;
  logic                          digit_blank;
  logic [PAGE_W-1:0]             page_idx;

  modport master (
    output src_words, src_sel, page_step, auto_scroll, blank_lz,
    input  anode, hex_digit, digit_blank, page_idx
  );

  modport slave (
    input  src_words, src_sel, page_step, auto_scroll, blank_lz,
    output anode, hex_digit, digit_blank, page_idx
  );
endinterface

// File: rtl/hex_display_pager.sv
// Multiplexed hex-display front end. Picks one source word, freezes it in a
// snapshot once per display frame so the digits never tear, and scans one
// page of NUM_DIGITS nibbles across the anodes. Pages advance on a
// synchronized, lockout-debounced push-button or on a timed auto-scroll.
module hex_display_pager #(
  parameter int NUM_DIGITS  = 4,
  parameter int NUM_SOURCES = 2,
  parameter int SEL_W       = 1,
  parameter int WORD_W      = 32,
  parameter int PAGE_W      = 1,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 2000
) (
  input logic                clk,
  input logic                reset,
  hex_display_pager_if.slave bus
);

  localparam int NUM_NIB   = WORD_W / 4;
  localparam int NUM_PAGES = WORD_W / (4 * NUM_DIGITS);
  localparam int RC_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SC_W      = $clog2(SCROLL_DIV + 1);
  localparam int NIB_W     = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam int LOCK_FRAMES = 4;

  logic [RC_W-1:0]       refresh_cnt_q, refresh_cnt_d;
  logic [DG_W-1:0]       digit_q, digit_d;
  logic [SC_W-1:0]       scroll_cnt_q, scroll_cnt_d;
  logic                  sync1_q, sync2_q, sync3_q;
  logic [2:0]            lock_q, lock_d;
  logic [WORD_W-1:0]     snapshot_q, snapshot_d;
  logic [SEL_W-1:0]      last_sel_q, last_sel_d;
  logic [PAGE_W-1:0]     pending_page_q, pending_page_d;
  logic [PAGE_W-1:0]     shown_page_q, shown_page_d;
  logic                  load_pending_q, load_pending_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [3:0]            hex_q, hex_d;
  logic                  blank_q, blank_d;

  logic                  tick;
  logic                  frame_end;
  logic                  step_rise;
  logic                  step_accept;
  logic                  scroll_inc;
  logic                  page_inc;
  logic                  snap_en;
  logic                  sel_changed;
  logic [WORD_W-1:0]     sel_word;
  logic [NUM_NIB-1:0]    lz_mask;
  logic                  lz_run;
  logic [NIB_W-1:0]      nib_idx;

  // Digit-slot timer and scan position; frame_end marks the last slot's tick.
  always_comb begin
    tick          = (refresh_cnt_q == RC_W'(REFRESH_DIV - 1));
    refresh_cnt_d = tick ? '0 : refresh_cnt_q + RC_W'(1);
    digit_d       = digit_q;
    if (tick) begin
      digit_d = (digit_q == DG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DG_W'(1);
    end
    frame_end = tick && (digit_q == DG_W'(NUM_DIGITS - 1));
  end

  // Push-button edge detect with frame-count lockout, and the auto-scroll frame counter.
  always_comb begin
    step_rise   = sync2_q & ~sync3_q;
    step_accept = step_rise && (lock_q == 3'd0);
    lock_d      = lock_q;
    if (step_accept) begin
      lock_d = 3'(LOCK_FRAMES);
    end else if (frame_end && (lock_q != 3'd0)) begin
      lock_d = lock_q - 3'd1;
    end

    scroll_inc   = 1'b0;
    scroll_cnt_d = scroll_cnt_q;
    if (!bus.auto_scroll) begin
      scroll_cnt_d = '0;
    end else if (frame_end) begin
      if (scroll_cnt_q == SC_W'(SCROLL_DIV - 1)) begin
        scroll_cnt_d = '0;
        scroll_inc   = 1'b1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + SC_W'(1);
      end
    end
    page_inc = step_accept | scroll_inc;
  end

  // Source selection, page bookkeeping and the once-per-frame snapshot.
  always_comb begin
    sel_word = bus.src_words[WORD_W-1:0];
    for (int k = 1; k < NUM_SOURCES; k++) begin
      if (bus.src_sel == SEL_W'(k)) begin
        sel_word = bus.src_words[k*WORD_W +: WORD_W];
      end
    end

    pending_page_d = pending_page_q;
    if (page_inc) begin
      pending_page_d = (pending_page_q == PAGE_W'(NUM_PAGES - 1)) ?
                       '0 : pending_page_q + PAGE_W'(1);
    end

    snap_en        = frame_end | load_pending_q;
    sel_changed    = (bus.src_sel != last_sel_q);
    snapshot_d     = snapshot_q;
    last_sel_d     = last_sel_q;
    shown_page_d   = shown_page_q;
    load_pending_d = load_pending_q;
    if (snap_en) begin
      snapshot_d     = sel_word;
      last_sel_d     = bus.src_sel;
      load_pending_d = 1'b0;
      if (sel_changed) begin
        pending_page_d = '0;
        shown_page_d   = '0;
      end else begin
        shown_page_d = pending_page_d;
      end
    end
  end

  // Nibble lookup for the current digit, leading-zero mask and anode pattern.
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    for (int i = NUM_NIB - 1; i >= 0; i--) begin
      lz_run     = lz_run & (snapshot_q[i*4 +: 4] == 4'h0);
      lz_mask[i] = lz_run & (i != 0);
    end

    nib_idx = NIB_W'(shown_page_q) * NIB_W'(NUM_DIGITS)
            + NIB_W'(NUM_DIGITS - 1) - NIB_W'(digit_q);
    hex_d   = 4'h0;
    blank_d = 1'b0;
    for (int i = 0; i < NUM_NIB; i++) begin
      if (nib_idx == NIB_W'(i)) begin
        hex_d   = snapshot_q[i*4 +: 4];
        blank_d = bus.blank_lz & lz_mask[i];
      end
    end
    anode_d = ~(NUM_DIGITS'(1) << digit_q);
  end

  // State registers; reset blanks the display and arms the first snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt_q  <= '0;
      digit_q        <= '0;
      scroll_cnt_q   <= '0;
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      lock_q         <= 3'd0;
      snapshot_q     <= '0;
      last_sel_q     <= '0;
      pending_page_q <= '0;
      shown_page_q   <= '0;
      load_pending_q <= 1'b1;
      anode_q        <= '1;
      hex_q          <= 4'h0;
      blank_q        <= 1'b1;
    end else begin
      refresh_cnt_q  <= refresh_cnt_d;
      digit_q        <= digit_d;
      scroll_cnt_q   <= scroll_cnt_d;
      sync1_q        <= bus.page_step;
      sync2_q        <= sync1_q;
      sync3_q        <= sync2_q;
      lock_q         <= lock_d;
      snapshot_q     <= snapshot_d;
      last_sel_q     <= last_sel_d;
      pending_page_q <= pending_page_d;
      shown_page_q   <= shown_page_d;
      load_pending_q <= load_pending_d;
      anode_q        <= anode_d;
      hex_q          <= hex_d;
      blank_q        <= blank_d;
    end
  end

  assign bus.anode       = anode_q;
  assign bus.hex_digit   = hex_q;
  assign bus.digit_blank = blank_q;
  assign bus.page_idx    = shown_page_q;

endmodule

// File: tb/tb_hex_display_pager.sv
// Directed bench for hex_display_pager with a 4-clock digit slot (16-clock
// frame) and a 3-frame auto-scroll. Edge numbers in the comments count rising
// clock edges since the latest reset release; frame_end lands on every 16th.
module tb_hex_display_pager;

  logic clk;
  logic reset;
  int   edge_n;
  int   n_checks;
  int   n_fails;

  hex_display_pager_if #(
    .NUM_DIGITS(4), .NUM_SOURCES(2), .SEL_W(2), .WORD_W(32), .PAGE_W(1)
  ) bus ();

  hex_display_pager #(
    .NUM_DIGITS(4), .NUM_SOURCES(2), .SEL_W(2), .WORD_W(32), .PAGE_W(1),
    .REFRESH_DIV(4), .SCROLL_DIV(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [1:0] sel, input logic step,
                               input logic auto, input logic blz);
    bus.src_words   = {w1, w0};
    bus.src_sel     = sel;
    bus.page_step   = step;
    bus.auto_scroll = auto;
    bus.blank_lz    = blz;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fails++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic advanceTo(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic checkDigit(input string tag, input logic [3:0] an,
                            input logic [3:0] hx, input logic bl);
    checkOutput({tag, "_anode"}, 32'(bus.anode), 32'(an));
    checkOutput({tag, "_hex"},   32'(bus.hex_digit), 32'(hx));
    checkOutput({tag, "_blank"}, 32'(bus.digit_blank), 32'(bl));
  endtask

  task automatic checkPage(input string tag, input logic pg);
    checkOutput(tag, 32'(bus.page_idx), 32'(pg));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    edge_n   = 0;
    reset    = 1'b0;
    applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkDigit("rst", 4'b1111, 4'h0, 1'b1);
    checkPage("rst_page", 1'b0);
    reset  = 1'b1;
    edge_n = 0;

    $display("[TB] scan of page 0");
    advanceTo(1);  checkOutput("scan_e1_anode", 32'(bus.anode), 32'(4'b1110));
    advanceTo(2);  checkDigit("scan_d0", 4'b1110, 4'hA, 1'b0);
    checkPage("scan_page", 1'b0);
    advanceTo(4);  checkOutput("scan_hold_anode", 32'(bus.anode), 32'(4'b1110));
    advanceTo(5);  checkDigit("scan_d1", 4'b1101, 4'hB, 1'b0);
    advanceTo(9);  checkDigit("scan_d2", 4'b1011, 4'hC, 1'b0);
    advanceTo(13); checkDigit("scan_d3", 4'b0111, 4'hD, 1'b0);
    advanceTo(17); checkDigit("scan_wrap", 4'b1110, 4'hA, 1'b0);

    $display("[TB] page step and wrap");
    applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    advanceTo(21); applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    advanceTo(31); checkPage("step_before_frame", 1'b0);
    advanceTo(32); checkPage("step_after_frame", 1'b1);
    advanceTo(33); checkDigit("p1_d0", 4'b1110, 4'h1, 1'b0);
    advanceTo(37); checkDigit("p1_d1", 4'b1101, 4'h2, 1'b0);
    advanceTo(41); checkDigit("p1_d2", 4'b1011, 4'h3, 1'b0);
    advanceTo(45); checkDigit("p1_d3", 4'b0111, 4'h4, 1'b0);
    // Pressed inside the lockout window: must be ignored.
    applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    advanceTo(49); applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    advanceTo(65); checkPage("lockout_reject", 1'b1);
    advanceTo(81); applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    advanceTo(85); applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    advanceTo(95); checkPage("wrap_before", 1'b1);
    advanceTo(96); checkPage("wrap_after", 1'b0);
    advanceTo(97); checkDigit("wrap_d0", 4'b1110, 4'hA, 1'b0);

    $display("[TB] bounce and coincident step");
    for (int i = 0; i < 6; i++) begin
      advanceTo(145 + 2 * i);
      applyStimulus(32'h1234ABCD, 32'h0, 2'd0, (i % 2 == 0), 1'b0, 1'b0);
    end
    advanceTo(161); checkPage("bounce_one_inc", 1'b1);
    advanceTo(177); checkPage("bounce_no_extra", 1'b1);
    applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);
    advanceTo(221); applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0);
    advanceTo(223); checkPage("coinc_before", 1'b1);
    advanceTo(225); checkPage("coinc_single_inc", 1'b0);
    applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0);

    $display("[TB] auto-scroll");
    advanceTo(271); checkPage("scroll_hold", 1'b0);
    advanceTo(272); checkPage("scroll_step", 1'b1);
    advanceTo(319); checkPage("scroll_hold2", 1'b1);
    advanceTo(320); checkPage("scroll_wrap", 1'b0);
    applyStimulus(32'h1234ABCD, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] anti-tearing and source select");
    advanceTo(322); applyStimulus(32'h56789EF0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    advanceTo(323); checkDigit("tear_d0_old", 4'b1110, 4'hA, 1'b0);
    advanceTo(327); checkDigit("tear_d1_old", 4'b1101, 4'hB, 1'b0);
    advanceTo(337); checkDigit("tear_d0_new", 4'b1110, 4'h9, 1'b0);
    applyStimulus(32'h56789EF0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    advanceTo(341); applyStimulus(32'h56789EF0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    advanceTo(353); checkPage("src_page1", 1'b1);
    checkDigit("src_p1_d0", 4'b1110, 4'h5, 1'b0);
    applyStimulus(32'h56789EF0, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0);
    advanceTo(367); checkPage("sel_before_snap", 1'b1);
    advanceTo(369); checkPage("sel_page_reset", 1'b0);
    checkDigit("sel1_d0", 4'b1110, 4'hB, 1'b0);
    applyStimulus(32'h56789EF0, 32'hDEADBEEF, 2'd3, 1'b0, 1'b0, 1'b0);
    advanceTo(385); checkDigit("sel3_is_src0", 4'b1110, 4'h9, 1'b0);

    $display("[TB] leading-zero blanking");
    applyStimulus(32'h000000F0, 32'hDEADBEEF, 2'd3, 1'b0, 1'b0, 1'b1);
    advanceTo(401); checkDigit("lz_p0_d0", 4'b1110, 4'h0, 1'b1);
    applyStimulus(32'h000000F0, 32'hDEADBEEF, 2'd3, 1'b1, 1'b0, 1'b1);
    advanceTo(405); checkDigit("lz_p0_d1", 4'b1101, 4'h0, 1'b1);
    applyStimulus(32'h000000F0, 32'hDEADBEEF, 2'd3, 1'b0, 1'b0, 1'b1);
    advanceTo(409); checkDigit("lz_p0_d2", 4'b1011, 4'hF, 1'b0);
    advanceTo(413); checkDigit("lz_p0_d3", 4'b0111, 4'h0, 1'b0);
    advanceTo(417); checkPage("lz_page1", 1'b1);
    checkDigit("lz_p1_d0", 4'b1110, 4'h0, 1'b1);
    applyStimulus(32'h0, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b1);
    advanceTo(421); checkDigit("lz_p1_d1", 4'b1101, 4'h0, 1'b1);
    advanceTo(425); checkDigit("lz_p1_d2", 4'b1011, 4'h0, 1'b1);
    advanceTo(429); checkDigit("lz_p1_d3", 4'b0111, 4'h0, 1'b1);
    advanceTo(433); checkDigit("lz_zero_d0", 4'b1110, 4'h0, 1'b1);
    advanceTo(437); checkDigit("lz_zero_d1", 4'b1101, 4'h0, 1'b1);
    advanceTo(441); checkDigit("lz_zero_d2", 4'b1011, 4'h0, 1'b1);
    advanceTo(445); checkDigit("lz_zero_d3", 4'b0111, 4'h0, 1'b0);
    applyStimulus(32'h0, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b0);
    advanceTo(449); checkDigit("lz_off_d0", 4'b1110, 4'h0, 1'b0);

    $display("[TB] mid-frame reset");
    advanceTo(465); applyStimulus(32'h0, 32'hDEADBEEF, 2'd0, 1'b1, 1'b0, 1'b0);
    advanceTo(469); applyStimulus(32'h0, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b0);
    advanceTo(481); checkPage("pre_reset_page", 1'b1);
    advanceTo(483);
    reset = 1'b0;
    #2;
    checkDigit("midrst", 4'b1111, 4'h0, 1'b1);
    checkPage("midrst_page", 1'b0);
    applyStimulus(32'h1234ABCD, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b1;
    edge_n = 0;
    advanceTo(1); checkOutput("rel_e1_anode", 32'(bus.anode), 32'(4'b1110));
    advanceTo(2); checkDigit("rel_d0", 4'b1110, 4'hA, 1'b0);
    checkPage("rel_page", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
